ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Parametrised multiplexed seven-segment scan driver for N digits.
- Replaces the hand-written per-board scan and hex-decode logic in the top file.
- Adds per-digit dot points, per-digit blink, anti-ghost blanking, and a tear-free double-buffered load handshake.
- Sits between the game FSM/status logic and the board An/C pins.

Parameters:
N_DIGITS, 8, number of multiplexed digits (1..16)
SCAN_DIV, 131072, Clk cycles each digit is driven per frame (>=2)
BLANK_CYCLES, 512, cycles at start of each dwell with all anodes off (< SCAN_DIV)
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; capture glyph/dp/blink inputs into staging
glyph_in  in  5*N_DIGITS  5-bit glyph code per digit, digit k at [5k+4:5k]
dp_in  in  N_DIGITS  1 = dot point lit for digit k
blink_in  in  N_DIGITS  1 = digit k blinks
load_ack  out  1  one-cycle pulse when staged data is committed to display
frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0
An  out  N_DIGITS  anodes, active-low, one-hot-low or all high
Cath  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low

Behaviour:
- Async reset (Reset_n=0):
  - dwell counter=0, digit index=0, frame counter=0, blink phase=0 (visible).
  - pending=0; staging and shadow = all glyphs OFF (5'b10000), dp=0, blink=0.
  - An=all 1, Cath=8'hFF, load_ack=0, frame_done=0.
  - Outputs are registered; release is synchronous to Clk.
- Dwell counter:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the digit index increments; index wraps N_DIGITS-1 -> 0.
- frame_done:
  - Pulses the cycle after the index wraps to 0.
  - Period = N_DIGITS*SCAN_DIV cycles.
- Anode drive:
  - An[idx]=0 only while dwell counter >= BLANK_CYCLES; all An=1 otherwise.
  - Cath=8'hFF during blanking.
  - An/Cath are registered and share the same one-cycle latency from counter state.
- Glyph decode (segments abcdefg, 0=on):
  - 0-F = hex digits.
  - 10000 = OFF.
  - 10001 = Y (1000100).
  - 10010 = a (0000010).
  - 10011 = L (1110001).
  - 10100-11111 = OFF.
- Dp = ~dp of the current digit.
- Blink:
  - Frame counter counts frames 0..BLINK_FRAMES-1 and toggles blink phase on wrap.
  - When phase=1, any digit with blink=1 shows Cath=8'hFF; its anode still scans.
- Load handshake:
  - load=1 writes staging from the inputs and sets pending.
  - A repeated load before commit overwrites staging (latest wins), no error.
- Commit:
  - Happens on the index-wrap edge if pending=1: shadow <= staging (pre-edge value), pending cleared, load_ack pulses next cycle coincident with frame_done.
  - Display always shows shadow, so no frame mixes old and new data.
- Simultaneous load and wrap edge:
  - Commit uses the old staging.
  - New data is written to staging and pending stays 1, so the new data commits on the next frame.
- Reset mid-frame: everything returns to reset values immediately; pending data is discarded.
- No other input affects state; load while Reset_n=0 is ignored.

Test Plan:
1. Reset then idle, N_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 -> An sequence per frame 1111,1110,1110,1110,1111,1101,... (per-digit dwell of 4 cycles, 1 blank); Cath=8'hFF throughout (all OFF); frame_done every 16 cycles.
2. Load glyphs {3,2,1,0}, dp=4'b0001 mid-frame -> display unchanged until wrap; load_ack and frame_done in the same cycle; then digit0 Cath=8'b00000010, digit3 Cath=8'b00001101.
3. Load glyphs {13,12,11,10} (digits 3..0 = L,a,Y,OFF) -> digit3 Cath=8'b11100011, digit2=8'b00000101, digit1=8'b10001001, digit0=8'hFF; code 5'b11111 -> 8'hFF.
4. blink_in=4'b0010, BLINK_FRAMES=2 -> digit1 shows its glyph for 2 frames, 8'hFF for 2 frames, repeating; other digits unaffected; An unchanged.
5. Two loads before wrap (A then B), then a third load C exactly on the wrap cycle -> B committed at that wrap with one load_ack; C committed at the following wrap with a second load_ack.
6. Assert Reset_n=0 mid-dwell with pending=1 -> An=all 1, Cath=8'hFF immediately; after release no load_ack at the next wrap; display is all OFF.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with per-digit dot point and blink,
// anti-ghost blanking at the start of each dwell, and a frame-aligned double-buffered load.
module ssd_scan_driver #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned SCAN_DIV     = 131072,
    parameter int unsigned BLANK_CYCLES = 512,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  load,
    input  logic [5*N_DIGITS-1:0] glyph_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_in,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic [N_DIGITS-1:0]   An,
    output logic [7:0]            Cath
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DwellW-1:0] DwellLast  = DwellW'(SCAN_DIV - 1);
    localparam logic [DwellW-1:0] BlankEnd   = DwellW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0]   IdxLast    = IdxW'(N_DIGITS - 1);
    localparam logic [FrameW-1:0] FrameLast  = FrameW'(BLINK_FRAMES - 1);

    localparam logic [4:0] GlyphOff = 5'b10000;

    // Scan timing state
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic              phase_q, phase_d;
    logic              dwell_end;
    logic              wrap;

    // Staging (written by load) and shadow (what the display scans)
    logic [N_DIGITS-1:0][4:0] stage_glyph_q, stage_glyph_d;
    logic [N_DIGITS-1:0]      stage_dp_q, stage_dp_d;
    logic [N_DIGITS-1:0]      stage_blink_q, stage_blink_d;
    logic [N_DIGITS-1:0][4:0] shadow_glyph_q, shadow_glyph_d;
    logic [N_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0]      shadow_blink_q, shadow_blink_d;
    logic                     pending_q, pending_d;
    logic                     commit;

    // Registered outputs
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          cath_q, cath_d;
    logic                load_ack_q;
    logic                frame_done_q;

    logic [4:0] cur_glyph;
    logic       cur_dp;
    logic       cur_blink;

    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'b0000001;
            5'h01:   seg = 7'b1001111;
            5'h02:   seg = 7'b0010010;
            5'h03:   seg = 7'b0000110;
            5'h04:   seg = 7'b1001100;
            5'h05:   seg = 7'b0100100;
            5'h06:   seg = 7'b0100000;
            5'h07:   seg = 7'b0001111;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0000100;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b1100000;
            5'h0C:   seg = 7'b0110001;
            5'h0D:   seg = 7'b1000010;
            5'h0E:   seg = 7'b0110000;
            5'h0F:   seg = 7'b0111000;
            5'h11:   seg = 7'b1000100;
            5'h12:   seg = 7'b0000010;
            5'h13:   seg = 7'b1110001;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Dwell / digit / frame / blink-phase counters
    always_comb begin
        dwell_end = (dwell_q == DwellLast);
        wrap      = dwell_end && (idx_q == IdxLast);
        dwell_d   = dwell_end ? '0 : dwell_q + 1'b1;
        idx_d     = idx_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        if (dwell_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            if (frame_q == FrameLast) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Commit takes the pre-edge staging; a load on the same edge re-arms pending
    always_comb begin
        stage_glyph_d  = stage_glyph_q;
        stage_dp_d     = stage_dp_q;
        stage_blink_d  = stage_blink_q;
        shadow_glyph_d = shadow_glyph_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blink_d = shadow_blink_q;
        pending_d      = pending_q;
        commit         = wrap && pending_q;
        if (commit) begin
            shadow_glyph_d = stage_glyph_q;
            shadow_dp_d    = stage_dp_q;
            shadow_blink_d = stage_blink_q;
            pending_d      = 1'b0;
        end
        if (load) begin
            stage_glyph_d = glyph_in;
            stage_dp_d    = dp_in;
            stage_blink_d = blink_in;
            pending_d     = 1'b1;
        end
    end

    // Anode / cathode drive, one cycle behind the counter state
    always_comb begin
        cur_glyph = shadow_glyph_q[idx_q];
        cur_dp    = shadow_dp_q[idx_q];
        cur_blink = shadow_blink_q[idx_q];
        an_d      = '1;
        cath_d    = 8'hFF;
        if (dwell_q >= BlankEnd) begin
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (idx_q != IdxW'(k));
            end
            if (!(phase_q && cur_blink)) begin
                cath_d = {decode_glyph(cur_glyph), ~cur_dp};
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dwell_q        <= '0;
            idx_q          <= '0;
            frame_q        <= '0;
            phase_q        <= 1'b0;
            stage_glyph_q  <= {N_DIGITS{GlyphOff}};
            stage_dp_q     <= '0;
            stage_blink_q  <= '0;
            shadow_glyph_q <= {N_DIGITS{GlyphOff}};
            shadow_dp_q    <= '0;
            shadow_blink_q <= '0;
            pending_q      <= 1'b0;
            an_q           <= '1;
            cath_q         <= 8'hFF;
            load_ack_q     <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            dwell_q        <= dwell_d;
            idx_q          <= idx_d;
            frame_q        <= frame_d;
            phase_q        <= phase_d;
            stage_glyph_q  <= stage_glyph_d;
            stage_dp_q     <= stage_dp_d;
            stage_blink_q  <= stage_blink_d;
            shadow_glyph_q <= shadow_glyph_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blink_q <= shadow_blink_d;
            pending_q      <= pending_d;
            an_q           <= an_d;
            cath_q         <= cath_d;
            load_ack_q     <= commit;
            frame_done_q   <= wrap;
        end
    end

    assign An         = an_q;
    assign Cath       = cath_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a closed-form model of the scan (from edge counts and a
// log of sampled loads) pushes the expected outputs; a monitor pops and compares each cycle.
module tb_ssd_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned BF = 2;
    localparam int unsigned FL = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [19:0] glyph_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_in = '0;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  an;
    logic [7:0]  cath;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .N_DIGITS    (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .load      (load),
        .glyph_in  (glyph_in),
        .dp_in     (dp_in),
        .blink_in  (blink_in),
        .load_ack  (load_ack),
        .frame_done(frame_done),
        .An        (an),
        .Cath      (cath)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] cath;
        logic       fd;
        logic       ack;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ld_edge[$];
    logic [19:0] ld_glyph[$];
    logic [3:0]  ld_dp[$];
    logic [3:0]  ld_blink[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [6:0] seg_of(input logic [4:0] g);
        case (g)
            5'h00: return 7'b0000001;
            5'h01: return 7'b1001111;
            5'h02: return 7'b0010010;
            5'h03: return 7'b0000110;
            5'h04: return 7'b1001100;
            5'h05: return 7'b0100100;
            5'h06: return 7'b0100000;
            5'h07: return 7'b0001111;
            5'h08: return 7'b0000000;
            5'h09: return 7'b0000100;
            5'h0A: return 7'b0001000;
            5'h0B: return 7'b1100000;
            5'h0C: return 7'b0110001;
            5'h0D: return 7'b1000010;
            5'h0E: return 7'b0110000;
            5'h0F: return 7'b0111000;
            5'h11: return 7'b1000100;
            5'h12: return 7'b0000010;
            5'h13: return 7'b1110001;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs after c clock edges since reset release
    function automatic exp_t predict(input int unsigned c);
        exp_t        e;
        int unsigned p, dw, dg, fr;
        logic [19:0] g;
        logic [3:0]  d, b;
        logic        phase;
        e.an   = 4'hF;
        e.cath = 8'hFF;
        e.fd   = 1'b0;
        e.ack  = 1'b0;
        if (c == 0) return e;
        p  = (c - 1) % FL;
        dw = p % SD;
        dg = p / SD;
        fr = (c - 1) / FL;
        g  = {4{5'b10000}};
        d  = '0;
        b  = '0;
        // displayed frame shows the latest load sampled strictly before its first edge
        for (int i = ld_edge.size() - 1; i >= 0; i--) begin
            if (ld_edge[i] < fr * FL) begin
                g = ld_glyph[i];
                d = ld_dp[i];
                b = ld_blink[i];
                break;
            end
        end
        phase = ((fr / BF) % 2) == 1;
        if (dw >= BC) begin
            e.an = ~(4'b0001 << dg);
            if (!(phase && b[dg])) e.cath = {seg_of(g[5*dg +: 5]), ~d[dg]};
        end
        if (c % FL == 0) begin
            e.fd = 1'b1;
            for (int i = 0; i < ld_edge.size(); i++) begin
                if (ld_edge[i] >= c - FL && ld_edge[i] < c) e.ack = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    // Reference model: logs sampled loads and issues one expectation per edge
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            ld_edge.delete();
            ld_glyph.delete();
            ld_dp.delete();
            ld_blink.delete();
            exp_q.push_back(predict(0));
        end else begin
            cyc++;
            if (load) begin
                ld_edge.push_back(cyc);
                ld_glyph.push_back(glyph_in);
                ld_dp.push_back(dp_in);
                ld_blink.push_back(blink_in);
            end
            exp_q.push_back(predict(cyc));
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("an", 32'(an), 32'(e.an));
            check_val("cath", 32'(cath), 32'(e.cath));
            check_val("frame_done", 32'(frame_done), 32'(e.fd));
            check_val("load_ack", 32'(load_ack), 32'(e.ack));
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scramble_inputs();
        glyph_in = 20'($urandom());
        dp_in    = 4'($urandom());
        blink_in = 4'($urandom());
    endtask

    task automatic do_load(input logic [19:0] g, input logic [3:0] d, input logic [3:0] b);
        @(negedge clk);
        load     = 1'b1;
        glyph_in = g;
        dp_in    = d;
        blink_in = b;
        @(negedge clk);
        load = 1'b0;
        scramble_inputs();
    endtask

    // Load sampled on the edge whose index within the frame is r (0 = wrap edge)
    task automatic load_at_phase(input int unsigned r, input logic [19:0] g,
                                 input logic [3:0] d, input logic [3:0] b);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((cyc + 1) % FL) != r && n < FL + 2);
        if (((cyc + 1) % FL) != r) begin
            checks++;
            errors++;
            $display("FAIL load_phase t=%0t got=%0d expected=%0d", $time, (cyc + 1) % FL, r);
        end
        load     = 1'b1;
        glyph_in = g;
        dp_in    = d;
        blink_in = b;
        @(negedge clk);
        load = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_frame_done();
        int unsigned n = 0;
        while (frame_done !== 1'b1 && n < FL + 2) begin
            @(negedge clk);
            n++;
        end
        check_val("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_cath", 32'(cath), 32'hFF);
        check_val("rst_ack", 32'(load_ack), 32'd0);
        check_val("rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        load     = 1'b1;
        glyph_in = {5'd1, 5'd2, 5'd3, 5'd4};
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_frame_done();
        idle(2 * FL);

        load_at_phase(6, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0001, 4'b0000);
        idle(2 * FL);

        load_at_phase(3, {5'h13, 5'h12, 5'h11, 5'h10}, 4'b0000, 4'b0000);
        idle(2 * FL);
        load_at_phase(9, {5'h1F, 5'h14, 5'h0F, 5'h0A}, 4'b1010, 4'b0000);
        idle(2 * FL);

        load_at_phase(2, {5'h0E, 5'h08, 5'h07, 5'h05}, 4'b0000, 4'b0010);
        idle(5 * FL);

        load_at_phase(4, {5'h01, 5'h01, 5'h01, 5'h01}, 4'b1111, 4'b0000);
        load_at_phase(10, {5'h09, 5'h06, 5'h04, 5'h02}, 4'b0100, 4'b0000);
        load_at_phase(0, {5'h0B, 5'h0C, 5'h0D, 5'h0E}, 4'b1000, 4'b0001);
        idle(3 * FL);

        load_at_phase(5, {5'h08, 5'h08, 5'h08, 5'h08}, 4'b1111, 4'b0000);
        idle(3);
        apply_reset();
        idle(3 * FL);

        repeat (40) begin
            idle($urandom_range(0, 20));
            do_load(20'($urandom()), 4'($urandom()), 4'($urandom()));
        end
        idle(3 * FL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
